dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory slave: the responder end of the core's data request interface (req/gnt/rvalid, addr/we/be/wdata/rdata).
- Sits between the memory stage's data port and a word-addressed on-chip RAM.
- Grants requests, applies byte-enabled writes, returns in-order read/write responses after a fixed latency.
- Supports injected grant stalls, so the initiator's handshake logic is exercised in simulation and on FPGA.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, ≥ 4.
- LATENCY, 1, cycles from handshake edge to rvalid; legal 1..4.
- MAX_OUTSTANDING, 2, granted-but-unanswered transactions allowed; legal 1..4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- data_req_i  in  1  request valid from initiator.
- data_gnt_o  out  1  request accepted this cycle.
- data_addr_i  in  32  byte address; bits [1:0] ignored.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  4  byte enables for writes; ignored on reads.
- data_wdata_i  in  32  write data.
- data_rvalid_o  out  1  response valid, one cycle per transaction.
- data_rdata_o  out  32  read data; 0 when rvalid low or for writes.
- stall_i  in  1  test hook; forces data_gnt_o low while high.
- data_err_o  out  1  only when DMEM_ERR_EN is defined.

Behaviour:
- Reset (async assert, sync-safe release) clears:
  - data_rvalid_o = 0, data_rdata_o = 0, data_err_o = 0.
  - outstanding counter = 0; all latency-pipeline valid bits = 0.
  - data_gnt_o = 0 while rst_i is high.
  - RAM contents are not reset.
- Grant (combinational): data_gnt_o = data_req_i && !stall_i && !rst_i && (outstanding < MAX_OUTSTANDING).
- Handshake = data_req_i && data_gnt_o at a rising edge. Address, we, be and wdata are sampled only at handshake.
- Index = (data_addr_i − BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits; wraps modulo depth.
- Write at handshake edge:
  - RAM[index] byte i is updated iff data_be_i[i]; unselected bytes are unchanged.
  - be = 4'b0000 is a legal no-op that still produces a response.
- Read at handshake edge: RAM[index] is captured into latency stage 0.
- Read-after-write:
  - A read handshaked in a later cycle than a write to the same word returns the written data.
  - No same-cycle hazard exists: one handshake per cycle.
- Latency pipeline:
  - LATENCY-stage shift register of {valid, rdata, err}; stage LATENCY-1 drives the outputs.
  - data_rvalid_o rises exactly LATENCY cycles after the handshake edge (LATENCY=1 → next cycle).
  - Responses are strictly in order, one per handshake; write responses carry rdata = 0.
- Outstanding counter: +1 on handshake, −1 on rvalid, unchanged when both happen in the same cycle.
  - Never exceeds MAX_OUTSTANDING; never underflows.
  - Full (== MAX_OUTSTANDING) → gnt low even with req high; gnt re-asserts in the cycle rvalid retires an entry only from the next cycle on (counter-based).
- Request held high across gnt-low cycles: no state change until granted. Request dropped without grant: no effect.
- Reset mid-operation: in-flight responses are discarded, no rvalid after release, counter restarts at 0. Writes already handshaked remain committed.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined:
  - Out-of-range address (outside BASE_ADDR .. BASE_ADDR + DEPTH_WORDS*4 − 1) is still granted.
  - Write is suppressed; read returns rdata 0.
  - data_err_o = 1 in the same cycle as that transaction's rvalid, 0 otherwise.
- Not defined:
  - data_err_o port is absent.
  - Out-of-range addresses wrap via index truncation; no error indication.

Test Plan:
- Basic write/read, defaults (LATENCY=1): write addr 0x10, be 4'b1111, wdata 0xDEADBEEF, then read 0x10 → gnt same cycle each; write rvalid next cycle with rdata 0; read rvalid next cycle with rdata 0xDEADBEEF.
- Byte enables: word 0x20 = 0x11223344, write be 4'b0101 wdata 0xAABBCCDD, read 0x20 → 0x11BB33DD.
- Outstanding limit (LATENCY=3, MAX_OUTSTANDING=2): req held high for 5 cycles → handshakes in cycles 0 and 1, gnt low in cycles 2–3, re-grant in cycle 4 after the first rvalid in cycle 3; responses in order.
- Stall injection: stall_i high 3 cycles with req high on a read of 0x40 → gnt 0 for 3 cycles, no rvalid; single handshake after stall drops, exactly one rvalid.
- Reset mid-flight (LATENCY=4): handshake a read, assert rst_i 2 cycles later → rvalid never rises, counter 0, gnt follows req immediately after release.
- DMEM_ERR_EN, DEPTH_WORDS=1024: write 0x1000 wdata 0x5A5A5A5A then read 0x0000 → write response data_err_o=1; word 0 unchanged. Without the macro, the same write overwrites word 0 (wrap).

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: grants core data requests, applies byte-enabled writes to a word RAM
// and returns in-order responses after LATENCY cycles. Define DMEM_ERR_EN for out-of-range errors.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  input  logic        stall_i
`ifdef DMEM_ERR_EN
  ,
  output logic        data_err_o
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [CNT_W-1:0] outstanding_q;
  logic             pipe_valid_q [LATENCY];
  logic [31:0]      pipe_rdata_q [LATENCY];
  logic             pipe_err_q   [LATENCY];

  logic [31:0]      offset;
  logic [IDX_W-1:0] index;
  logic             handshake;
  logic             in_range;
  logic             wr_en;
  logic             unused_offset;

  assign offset    = data_addr_i - BASE_ADDR;
  assign index     = offset[IDX_W+1:2];
  // Byte-lane bits and (without range checking) upper offset bits do not take part in indexing.
  assign unused_offset = ^offset;

  assign data_gnt_o = data_req_i && !stall_i && !rst_i && (outstanding_q < MAX_CNT);
  assign handshake  = data_req_i && data_gnt_o;

`ifdef DMEM_ERR_EN
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
  assign in_range = ({1'b0, offset} < SPAN_BYTES);
`else
  assign in_range = 1'b1;
`endif

  assign wr_en = handshake && data_we_i && in_range;

  // RAM has no reset: contents survive rst_i, including writes already handshaked.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem[index][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_valid_q[i] <= 1'b0;
        pipe_rdata_q[i] <= '0;
        pipe_err_q[i]   <= 1'b0;
      end
    end else begin
      pipe_valid_q[0] <= handshake;
      pipe_rdata_q[0] <= (handshake && !data_we_i && in_range) ? mem[index] : '0;
      pipe_err_q[0]   <= handshake && !in_range;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_rdata_q[i] <= pipe_rdata_q[i-1];
        pipe_err_q[i]   <= pipe_err_q[i-1];
      end
    end
  end

  assign data_rvalid_o = pipe_valid_q[LATENCY-1];
  assign data_rdata_o  = pipe_rdata_q[LATENCY-1];

`ifdef DMEM_ERR_EN
  assign data_err_o = pipe_err_q[LATENCY-1];
`else
  logic unused_err;
  assign unused_err = pipe_err_q[LATENCY-1];
`endif

  // Retirement is seen one edge after rvalid appears, so a freed slot grants from the next cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
    end else begin
      case ({handshake, data_rvalid_o})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

endmodule
